// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline run controller: debug commands,
// sequencer states and the HALT opcode.
package mips_ctrl_pkg;

    localparam logic [1:0] CMD_NOP        = 2'b00;
    localparam logic [1:0] CMD_RUN        = 2'b01;
    localparam logic [1:0] CMD_STEP       = 2'b10;
    localparam logic [1:0] CMD_RESET_PIPE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4,
        ST_FLUSH  = 3'd5
    } state_e;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/sat_cycle_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones
// instead of wrapping.
module sat_cycle_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline: takes debug commands,
// gates stage enables, drains after HALT and counts executed cycles.
module pipeline_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned NB_CYCLES    = 32,
    parameter int unsigned NB_CMD       = 2,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned NB_DRAIN     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    input  logic [NB_CMD-1:0]    i_cmd,
    output logic                 o_cmd_ready,
    input  logic                 i_halt_detected,
    input  logic                 i_hazard_stall,
    output logic                 o_pc_enable,
    output logic                 o_if_id_enable,
    output logic                 o_pipe_enable,
    output logic                 o_id_bubble,
    output logic                 o_pipe_flush,
    output logic                 o_step_done,
    output logic                 o_halted,
    output logic                 o_busy,
    output logic [NB_CYCLES-1:0] o_cycle_count
);

    state_e              state_q, state_d;
    logic [NB_DRAIN-1:0] drain_cnt_q, drain_cnt_d;
    logic                step_done_q, step_done_d;
    logic                halt_eff;
    logic                cmd_fire;
    logic                cnt_clear;

    // A stalled HALT is not yet a HALT; it is recognised once the stall clears.
    assign halt_eff = i_halt_detected & ~i_hazard_stall;
    assign cmd_fire = i_cmd_valid & o_cmd_ready;

    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        step_done_d    = 1'b0;
        cnt_clear      = 1'b0;
        o_cmd_ready    = 1'b0;
        o_pc_enable    = 1'b0;
        o_if_id_enable = 1'b0;
        o_pipe_enable  = 1'b0;
        o_id_bubble    = 1'b0;
        o_pipe_flush   = 1'b0;
        o_halted       = 1'b0;
        o_busy         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (cmd_fire) begin
                    if (i_cmd == CMD_RUN) begin
                        state_d = ST_RUN;
                    end else if (i_cmd == CMD_STEP) begin
                        state_d = ST_STEP;
                    end else if (i_cmd == CMD_RESET_PIPE) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_RUN, ST_STEP: begin
                o_busy         = 1'b1;
                o_pipe_enable  = 1'b1;
                o_pc_enable    = ~i_hazard_stall & ~halt_eff;
                o_if_id_enable = ~i_hazard_stall & ~halt_eff;
                o_id_bubble    = i_hazard_stall | halt_eff;
                if (halt_eff) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = NB_DRAIN'(DRAIN_CYCLES);
                end else if (state_q == ST_STEP) begin
                    state_d     = ST_IDLE;
                    step_done_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                o_busy        = 1'b1;
                o_pipe_enable = 1'b1;
                o_id_bubble   = 1'b1;
                drain_cnt_d   = drain_cnt_q - NB_DRAIN'(1);
                if (drain_cnt_q == NB_DRAIN'(1)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                o_cmd_ready = 1'b1;
                o_halted    = 1'b1;
                // RUN/STEP/NOP are consumed here but have no effect.
                if (cmd_fire && (i_cmd == CMD_RESET_PIPE)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                o_pipe_flush = 1'b1;
                cnt_clear    = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            step_done_q <= step_done_d;
        end
    end

    assign o_step_done = step_done_q;

    sat_cycle_counter #(
        .Width (NB_CYCLES)
    ) u_cycle_counter (
        .clk_i   (i_clk),
        .rst_ni  (i_rst),
        .clear_i (cnt_clear),
        .en_i    (o_pipe_enable),
        .count_o (o_cycle_count)
    );

endmodule
